// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, request kinds and the latched grant.
package cpu_types_pkg;

  localparam int CPUID_W = 2;  // wide enough for up to 4 cores

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {K_IFETCH, K_DREAD, K_DWRITE} memarb_kind_t;

  typedef struct packed {
    logic [CPUID_W-1:0] cpu;
    memarb_kind_t       kind;
    word_t              addr;
    word_t              store;
  } memarb_grant_t;

  localparam word_t BAD_LOAD = 32'hBAD1BAD1;

  // Within one core a write beats a read, and any data access beats a fetch.
  function automatic memarb_kind_t kind_select(input logic dwen, input logic dren);
    if (dwen)      return K_DWRITE;
    else if (dren) return K_DREAD;
    else           return K_IFETCH;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo CPUS.
module rr_arbiter #(
  parameter int CPUS = 2,
  parameter int IW   = 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [CPUS-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int o = CPUS - 1; o >= 0; o--) begin
      c = (int'(ptr) + o) % CPUS;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates per-core I/D cache requests onto one single-ported RAM (IDLE/REQ handshake).
// Define MEMARB_TIMEOUT_EN to add a RAM wait watchdog that forces completion and sets sticky err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     iload,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 err
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  memarb_grant_t    grant_q, grant_d;
  logic [IW-1:0]    rr_q, rr_d;
  word_t [CPUS-1:0] iload_q, iload_d, dload_q, dload_d;

  logic [CPUS-1:0]  any_req, rr_grant, is_cpu;
  logic [IW-1:0]    rr_idx;
  logic             win_dwen, win_dren, held, done, timeout_hit;
  word_t            done_load;

  assign any_req  = iREN | dREN | dWEN;
  assign win_dwen = |(rr_grant & dWEN);
  assign win_dren = |(rr_grant & dREN);

  rr_arbiter #(.CPUS(CPUS), .IW(IW)) u_rr (
    .req   (any_req),
    .ptr   (rr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // The granted core must keep its originating strobe up, otherwise the access is aborted.
  always_comb begin
    case (grant_q.kind)
      K_DWRITE: held = |(is_cpu & dWEN);
      K_DREAD:  held = |(is_cpu & dREN);
      default:  held = |(is_cpu & iREN);
    endcase
  end

  assign done      = (state_q == REQ) && held && ((ramstate == ACCESS) || timeout_hit);
  assign done_load = (ramstate == ACCESS) ? ramload : BAD_LOAD;

  generate
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_cpu
      assign is_cpu[gi] = (grant_q.cpu == CPUID_W'(gi));
      assign iwait[gi]  = !(done && is_cpu[gi] && (grant_q.kind == K_IFETCH));
      assign dwait[gi]  = !(done && is_cpu[gi] && (grant_q.kind != K_IFETCH));
      assign iload[gi]  = !iwait[gi] ? done_load : iload_q[gi];
      assign dload[gi]  = (done && is_cpu[gi] && (grant_q.kind == K_DREAD)) ? done_load : dload_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    iload_d = iload;
    dload_d = dload;
    if (state_q == IDLE) begin
      if (|any_req) begin
        state_d       = REQ;
        grant_d.cpu   = CPUID_W'(rr_idx);
        grant_d.kind  = kind_select(win_dwen, win_dren);
        grant_d.addr  = (grant_d.kind == K_IFETCH) ? iaddr[rr_idx] : daddr[rr_idx];
        grant_d.store = dstore[rr_idx];
      end
    end else if (!held) begin
      state_d = IDLE;
    end else if (done) begin
      state_d = IDLE;
      for (int c = 0; c < CPUS; c++) begin
        if (is_cpu[c]) rr_d = (c == CPUS - 1) ? '0 : IW'(c + 1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  // Strobes come straight from flops, so an asynchronous reset drops them immediately.
  assign ramREN   = (state_q == REQ) && (grant_q.kind != K_DWRITE);
  assign ramWEN   = (state_q == REQ) && (grant_q.kind == K_DWRITE);
  assign ramaddr  = (state_q == REQ) ? grant_q.addr : '0;
  assign ramstore = ramWEN ? grant_q.store : '0;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeout_hit = (state_q == REQ) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    err_d = err_q | (done && (ramstate != ACCESS));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  // No watchdog: err is constant 0 for any legal TIMEOUT.
  assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized traffic vs a transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int TO   = 8;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [CPUS-1:0]  iREN, dREN, dWEN, iwait, dwait;
  word_t [CPUS-1:0] iaddr, daddr, dstore, iload, dload;
  logic             ramREN, ramWEN, err;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(CPUS), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic chk_single(input string name);
    chk(name, 32'(($countones(~iwait) + $countones(~dwait)) <= 1), 32'd1);
  endtask

  // Directed single-request vectors.
  typedef struct {
    int          cpu;
    logic        i, dr, dw;
    word_t       addr, store;
    int          lat;
    word_t       rload;
    logic        exp_ren, exp_wen;
    logic [1:0]  exp_iwait, exp_dwait;
    word_t       exp_iload, exp_dload;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int n, input vec_t v);
    step();
    iREN[v.cpu] = v.i; dREN[v.cpu] = v.dr; dWEN[v.cpu] = v.dw;
    iaddr[v.cpu] = v.addr; daddr[v.cpu] = v.addr; dstore[v.cpu] = v.store;
    sample();
    chk($sformatf("vec%0d_idle_waits", n), {iwait, dwait}, 4'hF);
    chk($sformatf("vec%0d_idle_strobes", n), {ramREN, ramWEN}, 2'b00);
    for (int k = 0; k <= v.lat; k++) begin
      step();
      ramstate = (k < v.lat) ? BUSY : ACCESS;
      ramload  = (k < v.lat) ? ~v.rload : v.rload;
      sample();
      chk($sformatf("vec%0d_ramREN", n), ramREN, v.exp_ren);
      chk($sformatf("vec%0d_ramWEN", n), ramWEN, v.exp_wen);
      chk($sformatf("vec%0d_ramaddr", n), ramaddr, v.addr);
      chk($sformatf("vec%0d_ramstore", n), ramstore, v.store);
      if (k < v.lat) begin
        chk($sformatf("vec%0d_wait_busy", n), {iwait, dwait}, 4'hF);
      end else begin
        chk($sformatf("vec%0d_iwait_done", n), iwait, v.exp_iwait);
        chk($sformatf("vec%0d_dwait_done", n), dwait, v.exp_dwait);
        chk($sformatf("vec%0d_iload_bypass", n), iload[v.cpu], v.exp_iload);
        chk($sformatf("vec%0d_dload_bypass", n), dload[v.cpu], v.exp_dload);
      end
    end
    for (int h = 0; h < 2; h++) begin
      step();
      iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE; ramload = $urandom;
      sample();
      chk($sformatf("vec%0d_after_waits", n), {iwait, dwait}, 4'hF);
      chk($sformatf("vec%0d_after_strobes", n), {ramREN, ramWEN}, 2'b00);
      chk($sformatf("vec%0d_iload_hold", n), iload[v.cpu], v.exp_iload);
      chk($sformatf("vec%0d_dload_hold", n), dload[v.cpu], v.exp_dload);
    end
    $display("vec %0d: cpu%0d i=%0b dr=%0b dw=%0b addr=0x%08h lat=%0d", n, v.cpu, v.i, v.dr, v.dw, v.addr, v.lat);
  endtask

  // Transaction-level reference state for random traffic.
  bit    m_ipend[CPUS], m_dpend[CPUS], m_dwr[CPUS];
  word_t m_ia[CPUS], m_da[CPUS], m_ds[CPUS];
  word_t m_il[CPUS], m_dl[CPUS];
  word_t m_mem[word_t];
  bit    m_busy;
  int    m_rr, m_cnt, m_cpu, m_kind, n_tx;
  word_t m_addr, m_store;

  function automatic word_t mem_rd(input word_t a);
    return m_mem.exists(a) ? m_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic run_random(input int cycles);
    for (int c = 0; c < CPUS; c++) begin
      m_ipend[c] = 0; m_dpend[c] = 0; m_dwr[c] = 0; m_il[c] = '0; m_dl[c] = '0;
    end
    m_busy = 0; m_rr = 0; n_tx = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      step();
      for (int c = 0; c < CPUS; c++) begin
        if (!m_ipend[c] && $urandom_range(0, 3) == 0) begin
          m_ipend[c] = 1; m_ia[c] = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        end
        if (!m_dpend[c] && $urandom_range(0, 2) == 0) begin
          m_dpend[c] = 1; m_dwr[c] = 1'($urandom_range(0, 1));
          m_da[c] = 32'h1000 + 32'($urandom_range(0, 15)) * 4; m_ds[c] = $urandom;
        end
        iREN[c] = m_ipend[c]; iaddr[c] = m_ia[c];
        dWEN[c] = m_dpend[c] && m_dwr[c];
        dREN[c] = m_dpend[c] && (!m_dwr[c] || 1'($urandom_range(0, 1)));
        daddr[c] = m_da[c]; dstore[c] = m_ds[c];
      end
      if (m_busy) begin
        ramstate = (m_cnt == 0) ? ACCESS : ramstate_t'($urandom_range(0, 3) == 2 ? 1 : $urandom_range(0, 3) % 2 ? 1 : 3);
        ramload  = (m_cnt == 0 && m_kind != 2) ? mem_rd(m_addr) : $urandom;
      end else begin
        ramstate = ramstate_t'($urandom_range(0, 3));
        ramload  = $urandom;
      end
      sample();
      chk_single("rnd_single_wait");
      if (!m_busy) begin
        chk("rnd_idle_waits", {iwait, dwait}, 4'hF);
        chk("rnd_idle_strobes", {ramREN, ramWEN}, 2'b00);
        for (int o = CPUS - 1; o >= 0; o--) begin
          int w;
          w = (m_rr + o) % CPUS;
          if (m_ipend[w] || m_dpend[w]) begin
            m_busy = 1; m_cpu = w;
            m_kind = m_dpend[w] ? (m_dwr[w] ? 2 : 1) : 0;
            m_addr = m_dpend[w] ? m_da[w] : m_ia[w];
            m_store = m_ds[w];
          end
        end
        m_cnt = $urandom_range(0, 3);
      end else begin
        chk("rnd_ramREN", ramREN, 32'(m_kind != 2));
        chk("rnd_ramWEN", ramWEN, 32'(m_kind == 2));
        chk("rnd_ramaddr", ramaddr, m_addr);
        if (m_kind == 2) chk("rnd_ramstore", ramstore, m_store);
        if (m_cnt == 0) begin
          logic [1:0] ei, ed;
          ei = '1; ed = '1;
          if (m_kind == 0) ei[m_cpu] = 1'b0; else ed[m_cpu] = 1'b0;
          if (m_kind == 0) m_il[m_cpu] = mem_rd(m_addr);
          if (m_kind == 1) m_dl[m_cpu] = mem_rd(m_addr);
          if (m_kind == 2) m_mem[m_addr] = m_store;
          chk("rnd_iwait", iwait, ei);
          chk("rnd_dwait", dwait, ed);
          for (int c = 0; c < CPUS; c++) begin
            chk($sformatf("rnd_iload%0d", c), iload[c], m_il[c]);
            chk($sformatf("rnd_dload%0d", c), dload[c], m_dl[c]);
          end
          if (m_kind == 0) m_ipend[m_cpu] = 0; else m_dpend[m_cpu] = 0;
          $display("tx %0d: cpu%0d kind=%0d addr=0x%08h", n_tx, m_cpu, m_kind, m_addr);
          m_rr = (m_cpu + 1) % CPUS;
          m_busy = 0;
          n_tx++;
        end else begin
          chk("rnd_busy_waits", {iwait, dwait}, 4'hF);
          m_cnt--;
        end
      end
    end
    chk("rnd_progress", 32'(n_tx > 20), 32'd1);
    step();
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int comp_cpu[6];
    int comp_cyc[6];
    int ncomp;
    int found;

    vecs[0] = '{0, 0, 1, 0, 32'h40,  32'h0,        3, 32'hDEADBEEF, 1, 0, 2'b11, 2'b10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1, 0, 0, 1, 32'h80,  32'h12345678, 2, 32'hFFFF0000, 0, 1, 2'b11, 2'b01, 32'h0,        32'h0};
    vecs[2] = '{1, 0, 1, 0, 32'h84,  32'h0,        0, 32'h0BADF00D, 1, 0, 2'b11, 2'b01, 32'h0,        32'h0BADF00D};
    vecs[3] = '{1, 0, 1, 1, 32'h88,  32'hA5A5A5A5, 1, 32'h11111111, 0, 1, 2'b11, 2'b01, 32'h0,        32'h0BADF00D};
    vecs[4] = '{0, 1, 0, 0, 32'h100, 32'h0,        0, 32'hCAFEF00D, 1, 0, 2'b10, 2'b11, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[5] = '{1, 1, 0, 0, 32'h200, 32'h0,        5, 32'h76543210, 1, 0, 2'b01, 2'b11, 32'h76543210, 32'h0BADF00D};
    vecs[6] = '{0, 0, 1, 0, 32'h44,  32'h0,        1, 32'h13572468, 1, 0, 2'b11, 2'b10, 32'hCAFEF00D, 32'h13572468};

    idle_inputs();
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    chk("reset_waits", {iwait, dwait}, 4'hF);
    chk("reset_loads", {iload, dload}, '0);
    chk("reset_strobes", {ramREN, ramWEN}, 2'b00);
    chk("reset_ramaddr", ramaddr, 32'h0);
    chk("reset_ramstore", ramstore, 32'h0);
    chk("reset_err", err, 1'b0);
    do_reset();

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // Same-core I and D together: data first, fetch afterwards.
    do_reset();
    step(); iREN = 2'b01; dREN = 2'b01; iaddr[0] = 32'h300; daddr[0] = 32'h48;
    sample(); chk("prio_idle_waits", {iwait, dwait}, 4'hF);
    step(); ramstate = ACCESS; ramload = 32'h22220000;
    sample();
    chk("prio_d_addr", ramaddr, 32'h48);
    chk("prio_d_dwait", dwait, 2'b10);
    chk("prio_d_iwait", iwait, 2'b11);
    chk("prio_d_dload", dload[0], 32'h22220000);
    step(); dREN = 2'b00; ramstate = FREE;
    sample(); chk("prio_gap_waits", {iwait, dwait}, 4'hF);
    step(); ramstate = ACCESS; ramload = 32'h33330000;
    sample();
    chk("prio_i_addr", ramaddr, 32'h300);
    chk("prio_i_iwait", iwait, 2'b10);
    chk("prio_i_dwait", dwait, 2'b11);
    chk("prio_i_iload", iload[0], 32'h33330000);
    step(); idle_inputs();
    $display("seq prio: done");

    // Two cores hammering dREN with immediate ACCESS.
    do_reset();
    ncomp = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (cyc == 0) begin
        dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = ACCESS;
      end
      ramload = 32'h1000 + 32'(cyc);
      sample();
      chk_single("alt_single_wait");
      if (dwait != 2'b11) begin
        int c;
        c = dwait[0] ? 1 : 0;
        if (ncomp < 6) begin comp_cpu[ncomp] = c; comp_cyc[ncomp] = cyc; end
        chk("alt_addr", ramaddr, (c == 0) ? 32'h10 : 32'h20);
        chk("alt_dload", dload[c], 32'h1000 + 32'(cyc));
        ncomp++;
      end
    end
    chk("alt_count", ncomp, 6);
    for (int k = 0; k < 6 && k < ncomp; k++) begin
      chk($sformatf("alt_cpu%0d", k), comp_cpu[k], k % 2);
      chk($sformatf("alt_cycle%0d", k), comp_cyc[k], 2 * k + 1);
    end
    step(); idle_inputs();
    $display("seq alternate: %0d completions", ncomp);

    // Abort: core0 drops dREN while waiting; rr must not advance.
    do_reset();
    step(); dREN = 2'b01; daddr[0] = 32'h50;
    sample();
    step(); ramstate = BUSY;
    sample(); chk("abort_ren_before", ramREN, 1'b1);
    step(); dREN = 2'b00;
    sample(); chk("abort_no_wait", {iwait, dwait}, 4'hF);
    step(); ramstate = ACCESS;
    sample();
    chk("abort_strobes", {ramREN, ramWEN}, 2'b00);
    chk("abort_waits", {iwait, dwait}, 4'hF);
    step(); dREN = 2'b11; daddr[0] = 32'h54; daddr[1] = 32'h58; ramstate = BUSY;
    sample();
    step();
    sample(); chk("abort_regrant_addr", ramaddr, 32'h54);
    step(); ramstate = ACCESS; ramload = 32'h5454;
    sample(); chk("abort_regrant_dwait", dwait, 2'b10);
    step(); idle_inputs();
    $display("seq abort: done");

    // Reset in the middle of a write.
    step(); dWEN = 2'b10; daddr[1] = 32'h60; dstore[1] = 32'h99;
    sample();
    step(); ramstate = BUSY;
    sample(); chk("rstmid_wen_before", ramWEN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("rstmid_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rstmid_addr", ramaddr, 32'h0);
    chk("rstmid_waits", {iwait, dwait}, 4'hF);
    do_reset();
    $display("seq reset-mid-req: done");

    // RAM stuck BUSY.
    step(); dREN = 2'b01; daddr[0] = 32'h70;
    sample();
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      step(); ramstate = BUSY; ramload = 32'h7777;
      sample();
      if (dwait[0] == 1'b0) begin
        found = k;
        chk("stuck_dload", dload[0], BAD_LOAD);
      end
    end
`ifdef MEMARB_TIMEOUT_EN
    chk("stuck_timeout_cycle", found, TO);
    step(); dREN = 2'b00;
    sample(); chk("stuck_err_set", err, 1'b1);
    repeat (3) begin step(); sample(); end
    chk("stuck_err_sticky", err, 1'b1);
    chk("stuck_dload_hold", dload[0], BAD_LOAD);
    do_reset();
    #1 chk("stuck_err_cleared", err, 1'b0);
`else
    chk("stuck_no_completion", found, 0);
    chk("stuck_err_zero", err, 1'b0);
    do_reset();
`endif
    $display("seq stuck-busy: completion at %0d", found);

    run_random(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
